// File: rtl/feature_match_sel_pkg.sv
// Shared encodings for the feature-match selector: FSM states and system phase codes.
package feature_match_sel_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [1:0] PH_IDLE  = 2'b00;
  localparam logic [1:0] PH_CMP_A = 2'b01;
  localparam logic [1:0] PH_CMP_B = 2'b10;
  localparam logic [1:0] PH_STOP  = 2'b11;

  // Both compare codes keep a frame alive; idle and stop abandon it.
  function automatic logic phase_active(input logic [1:0] phase);
    return (phase == PH_CMP_A) || (phase == PH_CMP_B);
  endfunction

endpackage

// File: rtl/feature_match_sel_if.sv
// Sample feed and result handshake between the feeder/consumer and the selector.
interface feature_match_sel_if #(
  parameter int MODN = 30,
  parameter int ACCW = 16,
  parameter int IDXW = 5
);
  logic [1:0]        state;
  logic [MODN*4-1:0] diff_bus;
  logic              sample_vld;
  logic              frame_end;
  logic              res_ready;
  logic              res_valid;
  logic [IDXW-1:0]   best_idx;
  logic [ACCW-1:0]   best_score;
  logic              busy;

  modport master (
    output state, diff_bus, sample_vld, frame_end, res_ready,
    input  res_valid, best_idx, best_score, busy
  );

  modport slave (
    input  state, diff_bus, sample_vld, frame_end, res_ready,
    output res_valid, best_idx, best_score, busy
  );
endinterface

// File: rtl/feature_match_sel_acc.sv
// One per-model score accumulator: adds a 4-bit difference per enabled cycle, saturating.
module feature_acc #(
  parameter int ACCW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            en,
  input  logic [3:0]      din,
  output logic [ACCW-1:0] acc
);

  logic [ACCW:0] sum;

  assign sum = {1'b0, acc} + {{(ACCW-3){1'b0}}, din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[ACCW] ? '1 : sum[ACCW-1:0];
    end
  end

endmodule

// File: rtl/feature_match_sel.sv
// Accumulates per-model differences over a frame, then scans sequentially for the
// lowest-score model and holds the result until the consumer accepts it.
module feature_match_sel
  import feature_match_sel_pkg::*;
#(
  parameter int MODN = 30,
  parameter int ACCW = 16,
  parameter int IDXW = 5
) (
  input logic               clk,
  input logic               rst_n,
  feature_match_sel_if.slave bus
);

  logic [1:0]      fsm;
  logic [ACCW-1:0] acc_val [MODN];
  logic [IDXW-1:0] scan_cnt;
  logic [IDXW-1:0] min_idx;
  logic [ACCW-1:0] min_score;
  logic [ACCW-1:0] acc_sel;
  logic            abort;
  logic            acc_clear;
  logic            acc_en;

  assign abort     = (fsm == ST_ACC) && !phase_active(bus.state);
  assign acc_clear = (fsm == ST_IDLE) || abort;
  assign acc_en    = (fsm == ST_ACC) && bus.sample_vld && !abort;
  assign bus.busy  = (fsm != ST_IDLE);

  for (genvar g = 0; g < MODN; g++) begin : g_acc
    feature_acc #(.ACCW(ACCW)) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (acc_clear),
      .en    (acc_en),
      .din   (bus.diff_bus[g*4 +: 4]),
      .acc   (acc_val[g])
    );
  end

  // Single read port into the accumulator bank feeding the one comparator.
  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < MODN; i++) begin
      if (scan_cnt == IDXW'(i)) acc_sel = acc_val[i];
    end
  end

  // The scan counter runs one step past the last model so the final minimum is
  // copied to the outputs on its own cycle, giving a MODN+1 frame_end-to-result delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm            <= ST_IDLE;
      scan_cnt       <= '0;
      min_idx        <= '0;
      min_score      <= '0;
      bus.res_valid  <= 1'b0;
      bus.best_idx   <= '0;
      bus.best_score <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (bus.state == PH_CMP_A) fsm <= ST_ACC;
        end
        ST_ACC: begin
          scan_cnt <= '0;
          if (abort)              fsm <= ST_IDLE;
          else if (bus.frame_end) fsm <= ST_SCAN;
        end
        ST_SCAN: begin
          if (scan_cnt == IDXW'(MODN)) begin
            bus.best_idx   <= min_idx;
            bus.best_score <= min_score;
            bus.res_valid  <= 1'b1;
            fsm            <= ST_HOLD;
          end else begin
            if (scan_cnt == '0 || acc_sel < min_score) begin
              min_idx   <= scan_cnt;
              min_score <= acc_sel;
            end
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        default: begin
          if (bus.res_valid && bus.res_ready) begin
            bus.res_valid <= 1'b0;
            fsm           <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feature_match_sel.sv
// Directed and randomized frames against a per-model sum/argmin reference model.
module tb_feature_match_sel;

  localparam int MODN = 30;
  localparam int ACCW = 16;
  localparam int IDXW = 5;
  localparam int SAT  = (1 << ACCW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int unsigned m_acc [MODN];

  always #5 clk = ~clk;

  feature_match_sel_if #(.MODN(MODN), .ACCW(ACCW), .IDXW(IDXW)) bus ();

  feature_match_sel #(.MODN(MODN), .ACCW(ACCW), .IDXW(IDXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MODN*4-1:0] fill(input logic [3:0] v);
    logic [MODN*4-1:0] d;
    for (int i = 0; i < MODN; i++) d[i*4 +: 4] = v;
    return d;
  endfunction

  function automatic logic [MODN*4-1:0] rand_diff();
    logic [MODN*4-1:0] d;
    for (int i = 0; i < MODN; i++) d[i*4 +: 4] = 4'($urandom_range(0, 15));
    return d;
  endfunction

  // Reference: plain saturating sums per model.
  task automatic drive(input logic [MODN*4-1:0] d, input logic vld, input logic fe);
    bus.diff_bus   = d;
    bus.sample_vld = vld;
    bus.frame_end  = fe;
    step();
    if (vld) begin
      for (int i = 0; i < MODN; i++) begin
        m_acc[i] = m_acc[i] + int'(d[i*4 +: 4]);
        if (m_acc[i] > SAT) m_acc[i] = SAT;
      end
    end
    bus.sample_vld = 1'b0;
    bus.frame_end  = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] ph);
    bus.state = 2'b01;
    step();
    check("busy_after_start", 64'(bus.busy), 64'd1);
    bus.state = ph;
    for (int i = 0; i < MODN; i++) m_acc[i] = 0;
  endtask

  task automatic wait_result(input string tag);
    int cyc;
    int unsigned exp_idx;
    int unsigned exp_score;
    cyc = 0;
    while (bus.res_valid !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(MODN + 1));
    exp_idx   = 0;
    exp_score = m_acc[0];
    for (int i = 1; i < MODN; i++) begin
      if (m_acc[i] < exp_score) begin
        exp_idx   = i;
        exp_score = m_acc[i];
      end
    end
    check({tag, "_idx"}, 64'(bus.best_idx), 64'(exp_idx));
    check({tag, "_score"}, 64'(bus.best_score), 64'(exp_score));
  endtask

  task automatic handshake(input string tag);
    logic [IDXW-1:0] held_idx;
    logic [ACCW-1:0] held_score;
    held_idx   = bus.best_idx;
    held_score = bus.best_score;
    bus.state     = 2'b00;
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(bus.res_valid), 64'd0);
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    check({tag, "_idx_kept"}, 64'(bus.best_idx), 64'(held_idx));
    check({tag, "_score_kept"}, 64'(bus.best_score), 64'(held_score));
  endtask

  task automatic expect_no_result(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    bus.state = 2'b00;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (bus.res_valid !== 1'b0) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [MODN*4-1:0] d;
    logic [IDXW-1:0]   hold_idx;
    logic [ACCW-1:0]   hold_score;
    int                len;

    bus.state      = 2'b00;
    bus.diff_bus   = '0;
    bus.sample_vld = 1'b0;
    bus.frame_end  = 1'b0;
    bus.res_ready  = 1'b0;
    rst_n          = 1'b0;
    step();
    step();
    check("reset_valid", 64'(bus.res_valid), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_idx", 64'(bus.best_idx), 64'd0);
    check("reset_score", 64'(bus.best_score), 64'd0);
    rst_n = 1'b1;
    step();

    // Basic: model 7 clearly lowest.
    start_frame(2'b01);
    d = fill(4'd5);
    d[7*4 +: 4] = 4'd1;
    for (int s = 0; s < 4; s++) drive(d, 1'b1, 1'b0);
    drive('0, 1'b0, 1'b1);
    wait_result("basic");
    check("basic_idx_const", 64'(bus.best_idx), 64'd7);
    check("basic_score_const", 64'(bus.best_score), 64'd4);
    handshake("basic");

    // Frame with no valid samples.
    start_frame(2'b01);
    drive(fill(4'd9), 1'b0, 1'b1);
    wait_result("empty");
    check("empty_score_const", 64'(bus.best_score), 64'd0);
    handshake("empty");

    // Tie between 3 and 12; last sample shares the frame_end cycle.
    start_frame(2'b10);
    d = fill(4'd2);
    d[3*4 +: 4]  = 4'd0;
    d[12*4 +: 4] = 4'd0;
    for (int s = 0; s < 7; s++) drive(d, 1'b1, 1'b0);
    drive(d, 1'b1, 1'b1);
    wait_result("tie");
    check("tie_idx_const", 64'(bus.best_idx), 64'd3);
    handshake("tie");

    // Reset mid-ACC forces outputs low immediately.
    start_frame(2'b01);
    for (int s = 0; s < 3; s++) drive(fill(4'd4), 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_acc_valid", 64'(bus.res_valid), 64'd0);
    check("rst_acc_busy", 64'(bus.busy), 64'd0);
    check("rst_acc_idx", 64'(bus.best_idx), 64'd0);
    check("rst_acc_score", 64'(bus.best_score), 64'd0);
    bus.state = 2'b00;
    #2;
    rst_n = 1'b1;
    expect_no_result("rst_acc_no_result", 40);

    // Reset mid-SCAN discards the frame.
    start_frame(2'b01);
    drive(fill(4'd6), 1'b1, 1'b1);
    for (int s = 0; s < 5; s++) step();
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    expect_no_result("rst_scan_no_result", 40);

    // Abort via idle phase, then a fresh frame excludes the aborted samples.
    start_frame(2'b01);
    for (int s = 0; s < 10; s++) drive(rand_diff(), 1'b1, 1'b0);
    bus.state = 2'b00;
    step();
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_valid", 64'(bus.res_valid), 64'd0);
    start_frame(2'b01);
    d = fill(4'd3);
    d[5*4 +: 4] = 4'd1;
    drive(d, 1'b1, 1'b0);
    drive(d, 1'b1, 1'b1);
    wait_result("after_abort");
    check("after_abort_idx_const", 64'(bus.best_idx), 64'd5);
    check("after_abort_score_const", 64'(bus.best_score), 64'd2);
    handshake("after_abort");

    // Stop phase beats a simultaneous frame_end.
    start_frame(2'b01);
    drive(fill(4'd1), 1'b1, 1'b0);
    bus.state = 2'b11;
    drive(fill(4'd1), 1'b1, 1'b1);
    check("abort_prio_busy", 64'(bus.busy), 64'd0);
    expect_no_result("abort_prio_no_result", 40);

    // Backpressure: HOLD ignores phase toggling until the handshake.
    start_frame(2'b01);
    for (int s = 0; s < 6; s++) drive(rand_diff(), 1'($urandom_range(0, 1)), 1'b0);
    drive(rand_diff(), 1'b1, 1'b1);
    wait_result("backpressure");
    hold_idx   = bus.best_idx;
    hold_score = bus.best_score;
    for (int c = 0; c < 10; c++) begin
      bus.state = (c % 2 == 0) ? 2'b01 : 2'b00;
      step();
      check("bp_valid", 64'(bus.res_valid), 64'd1);
      check("bp_busy", 64'(bus.busy), 64'd1);
      check("bp_idx", 64'(bus.best_idx), 64'(hold_idx));
      check("bp_score", 64'(bus.best_score), 64'(hold_score));
    end
    bus.state     = 2'b01;
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("bp_release_valid", 64'(bus.res_valid), 64'd0);
    check("bp_release_idle", 64'(bus.busy), 64'd0);
    step();
    check("bp_new_frame", 64'(bus.busy), 64'd1);
    bus.state = 2'b00;
    step();
    check("bp_new_frame_abort", 64'(bus.busy), 64'd0);

    // Saturation: every model pinned at the ceiling, index 0 wins the tie.
    start_frame(2'b01);
    for (int s = 0; s < 4999; s++) drive(fill(4'd15), 1'b1, 1'b0);
    drive(fill(4'd15), 1'b1, 1'b1);
    wait_result("saturate");
    check("sat_idx_const", 64'(bus.best_idx), 64'd0);
    check("sat_score_const", 64'(bus.best_score), 64'(SAT));
    check("sat_acc_first", 64'(dut.acc_val[0]), 64'(SAT));
    check("sat_acc_last", 64'(dut.acc_val[MODN-1]), 64'(SAT));
    handshake("saturate");

    // Randomized frames with gaps in sample_vld.
    for (int f = 0; f < 6; f++) begin
      start_frame(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
      len = $urandom_range(1, 25);
      for (int s = 0; s < len; s++) drive(rand_diff(), 1'($urandom_range(0, 1)), 1'b0);
      drive(rand_diff(), 1'($urandom_range(0, 1)), 1'b1);
      wait_result("random");
      handshake("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/feature_match_sel.md
FEATURE_MATCH_SEL -- requirements
Module: feature_match_sel

Interface
REQ-001 Parameter MODN, default 30: number of stored feature models compared in parallel.
REQ-002 Parameter ACCW, default 16: width of each per-model score accumulator.
REQ-003 Parameter IDXW, default 5: width of the model index (ceil(log2(MODN))).
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: reset; asynchronous, active-low.
REQ-006 Port state, input, 2: system phase; 2'b00 = idle, 2'b01/2'b10 = compare active, 2'b11 = stop.
REQ-007 Port diff_bus, input, MODN*4: per-model 4-bit differences; model i occupies bits [i*4 +: 4].
REQ-008 Port sample_vld, input, 1: diff_bus holds a valid sample this cycle; the feeder aligns it with diff_bus, including the feeder's one-cycle register latency.
REQ-009 Port frame_end, input, 1: single-cycle pulse marking the last sample of a frame.
REQ-010 Port res_ready, input, 1: consumer accepts the result.
REQ-011 Port res_valid, output, 1: best_idx and best_score are valid.
REQ-012 Port best_idx, output, IDXW: index of the lowest-score model.
REQ-013 Port best_score, output, ACCW: accumulated score of best_idx.
REQ-014 Port busy, output, 1: high in any FSM state other than IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, ACC, SCAN, HOLD.
REQ-016 IDLE SHALL hold all accumulators at 0 and move to ACC when state == 2'b01.
REQ-017 In ACC, each cycle with sample_vld = 1 SHALL add diff nibble i, zero-extended, to acc[i] for every i.
REQ-018 Accumulation SHALL saturate at 2^ACCW-1 and never wrap.
REQ-019 In ACC, frame_end = 1 SHALL move to SCAN; a sample_vld in the same cycle SHALL be included.
REQ-020 In ACC, state == 2'b00 or 2'b11 SHALL abort to IDLE and clear the accumulators, with no result; abort takes priority over a simultaneous frame_end.
REQ-021 SCAN SHALL examine one model per cycle, indices 0 to MODN-1, over MODN cycles; index counter IDXW bits, no wrap.
REQ-022 The running minimum SHALL use strict less-than, so the lowest index wins ties.
REQ-023 The minimum SHALL start at acc[0] with index 0.
REQ-024 After index MODN-1 the FSM SHALL enter HOLD with res_valid = 1.
REQ-025 If frame_end is sampled at edge k, res_valid SHALL rise after edge k+MODN+1 (31 cycles at default).
REQ-026 In SCAN and HOLD, the state input, sample_vld and frame_end SHALL be ignored.
REQ-027 In HOLD, res_valid, best_idx and best_score SHALL stay stable until res_valid & res_ready.
REQ-028 On res_valid & res_ready the FSM SHALL go to IDLE, drop res_valid and clear the accumulators in the next cycle; best_idx and best_score SHALL retain their values.
REQ-029 A frame with zero valid samples SHALL yield best_idx = 0 and best_score = 0.

Reset
REQ-030 rst_n low SHALL asynchronously force: FSM to IDLE; all accumulators, best_idx, best_score, res_valid, busy and the scan counter to 0.
REQ-031 Reset mid-ACC, mid-SCAN or mid-HOLD SHALL discard the frame; no res_valid after deassertion until a new full frame completes.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE = 0, ACC = 1, SCAN = 2, HOLD = 3) and the phase constants for 2'b00, 2'b01, 2'b10 and 2'b11.
REQ-033 A sub-module feature_acc (one saturating 4-bit-into-ACCW accumulator with clear and enable) SHALL be instantiated MODN times in a generate loop.
REQ-034 The minimum search SHALL be sequential (one comparator), not a combinational tree.

Verification
REQ-035 Reset: assert rst_n = 0 mid-ACC -> res_valid = 0, busy = 0, best_idx = 0, best_score = 0 immediately.
REQ-036 Basic: 4 samples with model 7 nibble = 1 and all others = 5, then frame_end -> best_idx = 7, best_score = 4, res_valid rises 31 cycles after frame_end.
REQ-037 Tie: models 3 and 12 nibble = 0, others = 2, 8 samples -> best_idx = 3, best_score = 0.
REQ-038 Saturation: all nibbles = 15 for 5000 samples -> every accumulator = 65535, best_idx = 0, best_score = 65535.
REQ-039 Abort: state -> 2'b00 after 10 samples in ACC -> IDLE, no res_valid; next 2-sample frame of model 5 = 1 yields best_score = 2, not including the aborted frame.
REQ-040 Backpressure: res_ready low for 10 cycles in HOLD while state toggles to 2'b01 -> outputs stable, no new frame starts until the handshake completes.
